// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU execute stage with valid/ready handshake on both sides.
// Define ALU_EXEC_FAST_SHIFT_EN to replace the bit-serial shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal_op
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  logic [1:0]         state_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   result_r;
  logic               zero_r;
  logic               branch_r;
  logic               illegal_r;

  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_br_s;
  logic               alu_ill_s;
  logic               iter_start_s;

  assign shamt_s = b[SHAMT_W-1:0];

  // Single-cycle datapath; in the iterative build shifts only resolve here when shamt is 0.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_br_s  = 1'b0;
    alu_ill_s = 1'b0;
    case (op)
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_ADD:  alu_res_s = a + b;
      OP_SUB:  alu_res_s = a - b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_NOR:  alu_res_s = ~(a | b);
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL:  alu_res_s = a << shamt_s;
      OP_SRL:  alu_res_s = a >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(a) >>> shamt_s);
`else
      OP_SLL:  alu_res_s = a;
      OP_SRL:  alu_res_s = a;
      OP_SRA:  alu_res_s = a;
`endif
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_BEQ: begin
        alu_res_s = {{(WIDTH-1){1'b0}}, (a == b)};
        alu_br_s  = (a == b);
      end
      OP_BNE: begin
        alu_res_s = {{(WIDTH-1){1'b0}}, (a != b)};
        alu_br_s  = (a != b);
      end
      default: alu_ill_s = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign iter_start_s = 1'b0;
`else
  logic [WIDTH-1:0]   work_r;
  logic [WIDTH-1:0]   step_s;
  logic [SHAMT_W-1:0] cnt_r;
  logic [3:0]         shop_r;

  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] sop, input logic [WIDTH-1:0] w);
    case (sop)
      OP_SLL:  return {w[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, w[WIDTH-1:1]};
      OP_SRA:  return {w[WIDTH-1], w[WIDTH-1:1]};
      default: return w;
    endcase
  endfunction

  assign iter_start_s = ((op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA)) &&
                        (shamt_s != {SHAMT_W{1'b0}});
  assign step_s = shift_step(shop_r, work_r);

  // Bit-serial shifter: load on acceptance, one position per cycle while in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r <= {WIDTH{1'b0}};
      cnt_r  <= {SHAMT_W{1'b0}};
      shop_r <= 4'b0000;
    end else if ((state_r == ST_IDLE) && in_valid && iter_start_s) begin
      work_r <= a;
      cnt_r  <= shamt_s;
      shop_r <= op;
    end else if (state_r == ST_SHIFT) begin
      work_r <= step_s;
      cnt_r  <= cnt_r - SHAMT_W'(1);
    end
  end
`endif

  // Control FSM and registered result/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      branch_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_r <= 1'b0;
            if (iter_start_s) begin
              state_r <= ST_SHIFT;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              result_r    <= alu_res_s;
              zero_r      <= (alu_res_s == {WIDTH{1'b0}});
              branch_r    <= alu_br_s;
              illegal_r   <= alu_ill_s;
            end
          end
        end
`ifndef ALU_EXEC_FAST_SHIFT_EN
        ST_SHIFT: begin
          // cnt_r holds the shifts still to do, so the step taken at count 1 is the final one.
          if (cnt_r <= SHAMT_W'(1)) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= step_s;
            zero_r      <= (step_s == {WIDTH{1'b0}});
            branch_r    <= 1'b0;
            illegal_r   <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign result       = result_r;
  assign zero         = zero_r;
  assign branch_taken = branch_r;
  assign illegal_op   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a driver pushes expected responses, a monitor pops and compares.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
  logic        illegal_op;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .branch_taken(branch_taken), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        br;
    logic        il;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int bp_req = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference behaviour written directly from the operation table.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int sh;
    sh = int'(y[4:0]);
    e.res = 32'd0; e.br = 1'b0; e.il = 1'b0; e.lat = 1; e.acc = 0;
    case (o)
      4'd0:  e.res = x & y;
      4'd1:  e.res = x | y;
      4'd2:  e.res = x + y;
      4'd3:  e.res = x - y;
      4'd6:  e.res = x ^ y;
      4'd9:  e.res = ~(x | y);
      4'd4:  begin e.res = x << sh; e.lat = sh + 1; end
      4'd7:  begin e.res = x >> sh; e.lat = sh + 1; end
      4'd8:  begin e.res = $unsigned($signed(x) >>> sh); e.lat = sh + 1; end
      4'd5:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12: e.res = (x < y) ? 32'd1 : 32'd0;
      4'd10: begin e.res = (x == y) ? 32'd1 : 32'd0; e.br = (x == y); end
      4'd11: begin e.res = (x != y) ? 32'd1 : 32'd0; e.br = (x != y); end
      default: e.il = 1'b1;
    endcase
`ifdef ALU_EXEC_FAST_SHIFT_EN
    e.lat = 1;
`endif
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 4'($urandom);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
      in_valid = 1'b0;
    end else begin
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      e = model(o, x, y);
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    logic prev;
    int   hold;
    exp_t cur;
    prev = 1'b0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        hold = 0;
        out_ready = 1'b0;
      end else begin
        if (sb.size() != 0) chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: out_valid with no pending op, result 0x%08h", result);
          end else begin
            cur = sb[0];
            if (!prev) begin
              hold = bp_req;
              bp_req = 0;
              chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
              chk("result", result, cur.res);
              chk("zero", 32'(zero), 32'(cur.z));
              chk("branch_taken", 32'(branch_taken), 32'(cur.br));
              chk("illegal_op", 32'(illegal_op), 32'(cur.il));
            end else begin
              chk("held_result", result, cur.res);
              chk("held_flags", {29'd0, zero, branch_taken, illegal_op}, {29'd0, cur.z, cur.br, cur.il});
            end
          end
          out_ready = (hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
          if (hold > 0) hold--;
          if (out_ready && sb.size() != 0) void'(sb.pop_front());
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check_reset();

    send(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    send(4'b0011, 32'd5, 32'd5);
    send(4'b1000, 32'h8000_0000, 32'd4);
    send(4'b0101, 32'hFFFF_FFFF, 32'd1);
    send(4'b1100, 32'hFFFF_FFFF, 32'd1);
    send(4'b1010, 32'h1234, 32'h1234);
    send(4'b1011, 32'h1234, 32'h1234);
    send(4'b1110, 32'hDEAD_BEEF, 32'h1);
    send(4'b0100, 32'hA5A5_0F0F, 32'h20);
    send(4'b0111, 32'h8000_0001, 32'd31);
    send(4'b1000, 32'h8000_0000, 32'd31);
    send(4'b1001, 32'h0F0F_0000, 32'h0000_F0F0);
    drain();

    bp_req = 4;
    send(4'b0110, 32'hCAFE_0000, 32'h0000_BABE);
    send(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    drain();

    send(4'b0100, 32'h0000_0001, 32'd20);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check_reset();
    repeat (30) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      if ($urandom_range(0, 5) == 0) y = x;
      if ($urandom_range(0, 9) == 0) bp_req = 3;
      send(o, x, y);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execution unit that consumes the 4-bit ALU Operation code produced by the ALU controller, together with two operands, and produces the registered result and flags.
- Sits between the decode/ALU-control stage and writeback/branch logic.
- Valid/ready handshake on input and output.
- Logic ops, add/sub and compares complete in 1 cycle; shifts iterate one bit position per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal $clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- op  input  4  Operation code (encoding below).
- a  input  WIDTH  operand A (rs1).
- b  input  WIDTH  operand B (rs2 or immediate); b[SHAMT_W-1:0] is the shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- branch_taken  output  1  BEQ/BNE condition true.
- illegal_op  output  1  op was 1101–1111.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; branch_taken=0; illegal_op=0; shift counter=0.
- Op encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0110 XOR; 1001 NOR.
  - 0100 SLL; 0111 SRL; 1000 SRA.
  - 0101 SLT (signed); 1100 SLTU (unsigned).
  - 1010 BEQ; 1011 BNE.
  - 1101–1111 illegal.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no overflow flag. SLT/SLTU/BEQ/BNE result = {WIDTH-1 zeros, cond}. BEQ cond a==b; BNE cond a!=b. branch_taken = cond for BEQ/BNE only, else 0. Illegal op: result=0, illegal_op=1.
- States:
  - IDLE: in_ready=1. On in_valid, capture op/a/b.
    - Non-shift op: compute, register outputs, go to DONE. Out_valid asserts the cycle after acceptance (latency 1).
    - Shift op with shamt=0: result=a, go to DONE (latency 1).
    - Shift op with shamt>0: load working reg=a, counter=shamt, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle shift working reg by 1 (SLL fill 0, SRL fill 0, SRA replicate MSB) and decrement counter. When counter reaches 0, register result and go to DONE. Total latency = shamt+1 cycles (shamt=31 → 32 cycles).
  - DONE: out_valid=1; outputs held stable; in_ready=0. On out_ready, go to IDLE. out_valid drops the next cycle.
- Back-to-back throughput: no input accepted in DONE. Max rate is one non-shift op per 2 cycles.
- Inputs ignored unless in_valid && in_ready. op/a/b changes during SHIFT/DONE have no effect.
- zero is computed from the final registered result, including branch/compare results.
- rst_n asserted mid-SHIFT or in DONE: immediately returns to reset values; the pending result is discarded.
- out_ready asserted while not in DONE: ignored.

Optional Feature:
- Macro ALU_EXEC_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. All ops have latency 1, the SHIFT state and counter are removed, and in_ready behaves identically otherwise.
- Undefined: iterative shift as specified above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release → in_ready=1, out_valid=0, result=0, zero=1.
- ADD a=0xFFFFFFFF b=0x00000001 op=0010 → out_valid 1 cycle later. SUB a=5 b=5 op=0011 → result=0, zero=1.
- SRA a=0x80000000 b=4 op=1000 → result=0xF8000000 after 5 cycles (1 with fast-shift macro); in_ready=0 throughout.
- SLT a=0xFFFFFFFF b=1 → result=1; SLTU with the same operands → result=0.
- BEQ a=b=0x1234 → branch_taken=1, result=1. BNE with the same operands → branch_taken=0, zero=1.
- Backpressure: hold out_ready=0 for 4 cycles in DONE → outputs stable, in_valid ignored. op=1110 → illegal_op=1, result=0. Reset pulse mid-SHIFT (shamt=20, cycle 6) → out_valid never asserts for that op.
